pong_engine: RTL
================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): FIELD_W 160 ball x range; FIELD_H 120 ball/paddle y range; X_W 8 x width; Y_W 7 y width; PADDLE_H 16 paddle height; PADDLE_STEP 2 paddle move per frame; TICK_DIV 416667 clk cycles per frame; SCORE_W 4 score width; WIN_SCORE 9 winning score; SERVE_FRAMES 60 serve delay; MAX_SPEED 3 max ball step.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 system clock; rst_n in 1 reset.
REQ-003 Reset is asynchronous and active-low on rst_n; single clock clk.
REQ-004 SHALL have ports: user_in in 8 controls: [0] P1 up, [1] P1 down, [2] P2 up, [3] P2 down, [4] start; other bits ignored.
REQ-005 SHALL have port mode in 1: 0 = right paddle AI, 1 = two-player.
REQ-006 SHALL have outputs x_ball X_W, y_ball Y_W, y_left Y_W, y_right Y_W (paddle top), left_score SCORE_W, right_score SCORE_W.
REQ-007 SHALL have outputs game_over 1, frame_tick 1 (one-cycle pulse), state 3 (FSM encoding per REQ-010).

Function
REQ-008 Frame counter SHALL count 0..TICK_DIV-1 and wrap; frame_tick SHALL be high exactly in the wrap cycle.
REQ-009 All game state SHALL update only in frame_tick cycles; registered outputs change the cycle after frame_tick.
REQ-010 FSM states: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-011 IDLE: user_in[4]=1 at tick -> SERVE; mode latched internally at this transition only.
REQ-012 SERVE: ball at (FIELD_W/2, FIELD_H/2), speed 1; wait counter counts SERVE_FRAMES ticks, then PLAY; paddles movable.
REQ-013 PLAY per tick: x += ±speed, y += ±speed by direction signs; paddles updated same tick.
REQ-014 Wall: next y <= 0 -> y=0, flip vy; next y >= FIELD_H-1 -> y=FIELD_H-1, flip vy.
REQ-015 Left paddle at column 2: ball moving left, next x <= 3 and y_ball in [y_left, y_left+PADDLE_H-1] -> x=3, flip vx, speed = min(speed+1, MAX_SPEED).
REQ-016 Right paddle at column FIELD_W-3: mirror of REQ-015, x=FIELD_W-4.
REQ-017 Miss: next x <= 0 -> right scores; next x >= FIELD_W-1 -> left scores; go to POINT; scorer's score +1 (saturating at WIN_SCORE).
REQ-018 Wall and paddle on same tick SHALL both apply (flip both signs).
REQ-019 POINT (one tick): a score = WIN_SCORE -> OVER, else SERVE; serve vx points toward player who lost the point; vy keeps sign.
REQ-020 OVER: game_over=1, ball frozen; user_in[4]=1 at tick -> clear scores, SERVE with vx toward left.
REQ-021 Paddles: up subtracts PADDLE_STEP, down adds it; up and down both high -> no move; clamp to [0, FIELD_H-PADDLE_H].
REQ-022 Right paddle in AI mode: in SERVE/PLAY moves by PADDLE_STEP toward aligning centre (y_right+PADDLE_H/2) with y_ball, only while vx is rightward; no move if |diff| < PADDLE_STEP.
REQ-023 Arithmetic SHALL use one extra signed bit to detect under/overflow before clamping; no wrap-around.
REQ-024 Paddles frozen in IDLE and OVER.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, frame counter 0, frame_tick 0, ball (FIELD_W/2, FIELD_H/2), vx left, vy down, speed 1, paddles (FIELD_H-PADDLE_H)/2, scores 0, game_over 0, mode latch 0.
REQ-026 Reset mid-game SHALL abandon all state; first frame_tick after release occurs TICK_DIV cycles later.

Verification (TICK_DIV=4 for sim)
REQ-027 Reset, idle 20 cycles -> frame_tick every 4th cycle, state 0, ball (80,60), paddles 52.
REQ-028 start at tick, SERVE_FRAMES=2 -> state 1 for 2 ticks, then 2; x_ball 80->79, y_ball 60->61.
REQ-029 Ball at y=1 moving up, speed 2 -> y=0 next tick, vy down, following tick y=2.
REQ-030 Ball moving left at x=4, y_left=52, y_ball=60 -> x=3, vx right, speed 2; y_left=0 instead -> left misses, right_score +1, state 3 then 1.
REQ-031 right_score=8, right scores -> right_score 9, state 4, game_over 1; start -> scores 0, state 1.
REQ-032 mode=1, user_in[2]=user_in[3]=1 -> y_right unchanged; mode=0, y_ball=0 -> y_right decreases 2/tick to 0 and holds.

Source files
------------

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - Pong game engine: frame timer, ball physics, paddles, scoring FSM.
// All game state advances only on the frame_tick cycle.
module pong_engine #(
   parameter int FIELD_W      = 160,
   parameter int FIELD_H      = 120,
   parameter int X_W          = 8,
   parameter int Y_W          = 7,
   parameter int PADDLE_H     = 16,
   parameter int PADDLE_STEP  = 2,
   parameter int TICK_DIV     = 416667,
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int MAX_SPEED    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         user_in,
   input  logic               mode,
   output logic [X_W-1:0]     x_ball,
   output logic [Y_W-1:0]     y_ball,
   output logic [Y_W-1:0]     y_left,
   output logic [Y_W-1:0]     y_right,
   output logic [SCORE_W-1:0] left_score,
   output logic [SCORE_W-1:0] right_score,
   output logic               game_over,
   output logic               frame_tick,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam int TCW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SC_W  = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam int SPD_W = $clog2(MAX_SPEED + 1);

   localparam logic [X_W-1:0] X_MID = X_W'(FIELD_W / 2);
   localparam logic [Y_W-1:0] Y_MID = Y_W'(FIELD_H / 2);
   localparam logic [Y_W-1:0] P_MID = Y_W'((FIELD_H - PADDLE_H) / 2);

   localparam logic signed [X_W:0]   SX_ZERO = '0;
   localparam logic signed [X_W:0]   SX_LPAD = (X_W+1)'(3);
   localparam logic signed [X_W:0]   SX_RPAD = (X_W+1)'(FIELD_W - 4);
   localparam logic signed [X_W:0]   SX_MAX  = (X_W+1)'(FIELD_W - 1);
   localparam logic signed [Y_W:0]   SY_ZERO = '0;
   localparam logic signed [Y_W:0]   SY_MAX  = (Y_W+1)'(FIELD_H - 1);
   localparam logic signed [Y_W:0]   SP_MAX  = (Y_W+1)'(FIELD_H - PADDLE_H);
   localparam logic signed [Y_W:0]   SP_STEP = (Y_W+1)'(PADDLE_STEP);
   localparam logic signed [Y_W+1:0] SD_STEP = (Y_W+2)'(PADDLE_STEP);
   localparam logic signed [Y_W+1:0] SD_HALF = (Y_W+2)'(PADDLE_H / 2);
   localparam logic [Y_W:0]          PAD_SPAN = (Y_W+1)'(PADDLE_H - 1);

   state_t             state_q, state_n;
   logic [TCW-1:0]     frame_cnt;
   logic [X_W-1:0]     x_q, x_n;
   logic [Y_W-1:0]     y_q, y_n;
   logic               vx_right_q, vx_right_n;
   logic               vy_down_q, vy_down_n;
   logic [SPD_W-1:0]   speed_q, speed_n;
   logic [Y_W-1:0]     yl_q, yl_n;
   logic [Y_W-1:0]     yr_q, yr_n;
   logic [SCORE_W-1:0] ls_q, ls_n;
   logic [SCORE_W-1:0] rs_q, rs_n;
   logic               mode_q, mode_n;
   logic [SC_W-1:0]    serve_q, serve_n;

   logic signed [X_W:0]   nx;
   logic signed [Y_W:0]   ny;
   logic signed [Y_W+1:0] ai_diff;
   logic                  in_left, in_right, go_serve;
   logic                  unused_in;

   assign unused_in = &{1'b0, user_in[7:5]};

   function automatic logic [Y_W-1:0] move_paddle(input logic [Y_W-1:0] p,
                                                  input logic up, input logic dn);
      logic signed [Y_W:0] t;
      t = $signed({1'b0, p});
      if (up && !dn)
         t = t - SP_STEP;
      else if (dn && !up)
         t = t + SP_STEP;
      if (t < SY_ZERO)
         t = SY_ZERO;
      else if (t > SP_MAX)
         t = SP_MAX;
      return t[Y_W-1:0];
   endfunction

   function automatic logic [SPD_W-1:0] speed_up(input logic [SPD_W-1:0] s);
      return (s < SPD_W'(MAX_SPEED)) ? s + 1'b1 : s;
   endfunction

   assign frame_tick = (frame_cnt == TCW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_cnt <= '0;
      else if (frame_tick)
         frame_cnt <= '0;
      else
         frame_cnt <= frame_cnt + 1'b1;
   end

   // Next position is computed one signed bit wider so walls and goal lines clamp instead of wrapping.
   always_comb begin
      nx = vx_right_q ? $signed({1'b0, x_q}) + $signed((X_W+1)'(speed_q))
                      : $signed({1'b0, x_q}) - $signed((X_W+1)'(speed_q));
      ny = vy_down_q  ? $signed({1'b0, y_q}) + $signed((Y_W+1)'(speed_q))
                      : $signed({1'b0, y_q}) - $signed((Y_W+1)'(speed_q));
      in_left  = ({1'b0, y_q} >= {1'b0, yl_q}) && ({1'b0, y_q} <= {1'b0, yl_q} + PAD_SPAN);
      in_right = ({1'b0, y_q} >= {1'b0, yr_q}) && ({1'b0, y_q} <= {1'b0, yr_q} + PAD_SPAN);
      ai_diff  = $signed({2'b00, y_q}) - ($signed({2'b00, yr_q}) + SD_HALF);
   end

   always_comb begin
      state_n    = state_q;
      x_n        = x_q;
      y_n        = y_q;
      vx_right_n = vx_right_q;
      vy_down_n  = vy_down_q;
      speed_n    = speed_q;
      yl_n       = yl_q;
      yr_n       = yr_q;
      ls_n       = ls_q;
      rs_n       = rs_q;
      mode_n     = mode_q;
      serve_n    = serve_q;
      go_serve   = 1'b0;

      if (state_q == S_SERVE || state_q == S_PLAY || state_q == S_POINT) begin
         yl_n = move_paddle(yl_q, user_in[0], user_in[1]);
         if (mode_q)
            yr_n = move_paddle(yr_q, user_in[2], user_in[3]);
         else if (state_q != S_POINT && vx_right_q)
            yr_n = move_paddle(yr_q, ai_diff <= -SD_STEP, ai_diff >= SD_STEP);
      end

      case (state_q)
         S_IDLE: begin
            if (user_in[4]) begin
               mode_n   = mode;
               go_serve = 1'b1;
            end
         end
         S_SERVE: begin
            if (serve_q == SC_W'(SERVE_FRAMES - 1)) begin
               state_n = S_PLAY;
               serve_n = '0;
            end else begin
               serve_n = serve_q + 1'b1;
            end
         end
         S_PLAY: begin
            if (ny <= SY_ZERO) begin
               y_n       = '0;
               vy_down_n = 1'b1;
            end else if (ny >= SY_MAX) begin
               y_n       = SY_MAX[Y_W-1:0];
               vy_down_n = 1'b0;
            end else begin
               y_n = ny[Y_W-1:0];
            end
            if (!vx_right_q && nx <= SX_LPAD && in_left) begin
               x_n        = SX_LPAD[X_W-1:0];
               vx_right_n = 1'b1;
               speed_n    = speed_up(speed_q);
            end else if (vx_right_q && nx >= SX_RPAD && in_right) begin
               x_n        = SX_RPAD[X_W-1:0];
               vx_right_n = 1'b0;
               speed_n    = speed_up(speed_q);
            end else if (nx <= SX_ZERO) begin
               // Next serve heads toward the player who just lost the point.
               x_n        = '0;
               vx_right_n = 1'b0;
               rs_n       = (rs_q == SCORE_W'(WIN_SCORE)) ? rs_q : rs_q + 1'b1;
               state_n    = S_POINT;
            end else if (nx >= SX_MAX) begin
               x_n        = SX_MAX[X_W-1:0];
               vx_right_n = 1'b1;
               ls_n       = (ls_q == SCORE_W'(WIN_SCORE)) ? ls_q : ls_q + 1'b1;
               state_n    = S_POINT;
            end else begin
               x_n = nx[X_W-1:0];
            end
         end
         S_POINT: begin
            if (ls_q == SCORE_W'(WIN_SCORE) || rs_q == SCORE_W'(WIN_SCORE))
               state_n = S_OVER;
            else
               go_serve = 1'b1;
         end
         S_OVER: begin
            if (user_in[4]) begin
               ls_n       = '0;
               rs_n       = '0;
               vx_right_n = 1'b0;
               go_serve   = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (go_serve) begin
         state_n = S_SERVE;
         x_n     = X_MID;
         y_n     = Y_MID;
         speed_n = SPD_W'(1);
         serve_n = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         x_q        <= X_MID;
         y_q        <= Y_MID;
         vx_right_q <= 1'b0;
         vy_down_q  <= 1'b1;
         speed_q    <= SPD_W'(1);
         yl_q       <= P_MID;
         yr_q       <= P_MID;
         ls_q       <= '0;
         rs_q       <= '0;
         mode_q     <= 1'b0;
         serve_q    <= '0;
      end else if (frame_tick) begin
         state_q    <= state_n;
         x_q        <= x_n;
         y_q        <= y_n;
         vx_right_q <= vx_right_n;
         vy_down_q  <= vy_down_n;
         speed_q    <= speed_n;
         yl_q       <= yl_n;
         yr_q       <= yr_n;
         ls_q       <= ls_n;
         rs_q       <= rs_n;
         mode_q     <= mode_n;
         serve_q    <= serve_n;
      end
   end

   assign x_ball      = x_q;
   assign y_ball      = y_q;
   assign y_left      = yl_q;
   assign y_right     = yr_q;
   assign left_score  = ls_q;
   assign right_score = rs_q;
   assign game_over   = (state_q == S_OVER);
   assign state       = state_q;

endmodule
